// File: rtl/daq_frame_packer.sv
// Buffers ADC word strobes in a FIFO and emits fixed-length frames
// (header, frame number, payload, trailer) over a valid/ready output.
module daq_frame_packer #(
  parameter int unsigned FRAME_WORDS = 16,
  parameter int unsigned FIFO_AW     = 5,
  parameter logic [15:0] HEADER      = 16'hEB90,
  parameter logic [15:0] TRAILER     = 16'h55AA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iRunStart,
  input  logic        iData_en,
  input  logic [15:0] iData,
  input  logic        iOutReady,
  output logic        oData_en,
  output logic [15:0] oData,
  output logic        oFrameStart,
  output logic        oFrameEnd,
  output logic        oOverflow,
  output logic [15:0] oFrameCnt
);

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FNUM,
    S_PAYLOAD,
    S_TRAILER
  } state_t;

  state_t             state;
  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] pld_cnt;
  logic [CW-1:0]      count;
  logic               run_q;

  logic               xfer_c;
  logic               pop_c;
  logic               wr_req_c;
  logic               push_c;
  logic               drop_c;
  logic               run_rise_c;
  logic [FIFO_AW-1:0] rd_next_c;

  // Handshake and FIFO control; a full FIFO still accepts when a payload pop frees a slot.
  always_comb begin
    xfer_c     = oData_en && iOutReady;
    pop_c      = xfer_c && (state == S_PAYLOAD);
    wr_req_c   = iRunStart && iData_en;
    push_c     = wr_req_c && ((count < CW'(DEPTH)) || pop_c);
    drop_c     = wr_req_c && !push_c;
    run_rise_c = iRunStart && !run_q;
    rd_next_c  = rd_ptr + FIFO_AW'(1);
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= iData;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_next_c;
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Run-edge detection, overflow flag and completed-frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q     <= 1'b0;
      oOverflow <= 1'b0;
      oFrameCnt <= '0;
    end else begin
      run_q <= iRunStart;
      if (run_rise_c) begin
        oFrameCnt <= '0;
      end else if (xfer_c && (state == S_TRAILER)) begin
        oFrameCnt <= oFrameCnt + 16'd1;
      end
      // A drop on the run-start edge still reports, since the word belongs to the new run.
      if (drop_c) begin
        oOverflow <= 1'b1;
      end else if (run_rise_c) begin
        oOverflow <= 1'b0;
      end
    end
  end

  // Frame sequencer; each state loads the next word's registered outputs on transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      oData_en    <= 1'b0;
      oData       <= '0;
      oFrameStart <= 1'b0;
      oFrameEnd   <= 1'b0;
      pld_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count >= CW'(FRAME_WORDS)) begin
            state       <= S_HEADER;
            oData_en    <= 1'b1;
            oData       <= HEADER;
            oFrameStart <= 1'b1;
          end
        end
        S_HEADER: begin
          if (xfer_c) begin
            state       <= S_FNUM;
            oData       <= oFrameCnt;
            oFrameStart <= 1'b0;
          end
        end
        S_FNUM: begin
          if (xfer_c) begin
            state   <= S_PAYLOAD;
            oData   <= mem[rd_ptr];
            pld_cnt <= '0;
          end
        end
        S_PAYLOAD: begin
          if (xfer_c) begin
            if (pld_cnt == FIFO_AW'(FRAME_WORDS - 1)) begin
              state     <= S_TRAILER;
              oData     <= TRAILER;
              oFrameEnd <= 1'b1;
            end else begin
              pld_cnt <= pld_cnt + FIFO_AW'(1);
              oData   <= mem[rd_next_c];
            end
          end
        end
        S_TRAILER: begin
          if (xfer_c) begin
            state     <= S_IDLE;
            oData_en  <= 1'b0;
            oFrameEnd <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          oData_en    <= 1'b0;
          oFrameStart <= 1'b0;
          oFrameEnd   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_daq_frame_packer.sv
// Bench for daq_frame_packer: two instances (FRAME_WORDS 4 and 16) share stimulus;
// a frame-level reference model tracks accepted words and the expected output stream.
module tb_daq_frame_packer;

  localparam logic [15:0] HDR   = 16'hEB90;
  localparam logic [15:0] TRL   = 16'h55AA;
  localparam int          DEPTH = 32;
  localparam logic [15:0] BEXP [7] = '{16'hEB90, 16'h0000, 16'h0000, 16'h0001,
                                       16'h0002, 16'h0003, 16'h55AA};

  logic        clk = 1'b0;
  logic        reset;
  logic        iRunStart;
  logic        iData_en;
  logic [15:0] iData;
  logic        iOutReady;

  logic        o_en   [2];
  logic [15:0] o_data [2];
  logic        o_fs   [2];
  logic        o_fe   [2];
  logic        o_ovf  [2];
  logic [15:0] o_cnt  [2];

  daq_frame_packer #(.FRAME_WORDS(4)) dut_a (
    .clk(clk), .reset(reset), .iRunStart(iRunStart), .iData_en(iData_en),
    .iData(iData), .iOutReady(iOutReady), .oData_en(o_en[0]), .oData(o_data[0]),
    .oFrameStart(o_fs[0]), .oFrameEnd(o_fe[0]), .oOverflow(o_ovf[0]), .oFrameCnt(o_cnt[0])
  );

  daq_frame_packer #(.FRAME_WORDS(16)) dut_b (
    .clk(clk), .reset(reset), .iRunStart(iRunStart), .iData_en(iData_en),
    .iData(iData), .iOutReady(iOutReady), .oData_en(o_en[1]), .oData(o_data[1]),
    .oFrameStart(o_fs[1]), .oFrameEnd(o_fe[1]), .oOverflow(o_ovf[1]), .oFrameCnt(o_cnt[1])
  );

  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          cyc;
  logic [15:0] got_w [2][$];
  logic [1:0]  got_f [2][$];
  int          got_c [2][$];
  logic [15:0] acc   [2][$];
  int          occ [2];
  int          pos [2];
  int          stall_err [2];
  logic        m_ovf [2];
  logic [15:0] m_fcnt [2];
  logic        held [2];
  logic [15:0] h_data [2];
  logic        h_fs [2];
  logic        h_fe [2];
  logic        run_prev;

  function automatic int fw(input int k);
    return (k == 0) ? 4 : 16;
  endfunction

  // Expected i-th transferred word since reset: frames of HDR, number, payload, TRL.
  function automatic logic [15:0] exp_word(input int k, input int i);
    int fl, f, p, idx;
    fl = fw(k) + 3;
    f  = i / fl;
    p  = i % fl;
    if (p == 0) return HDR;
    if (p == 1) return 16'(f);
    if (p == fl - 1) return TRL;
    idx = f * fw(k) + p - 2;
    if (idx < acc[k].size()) return acc[k][idx];
    return 'x;
  endfunction

  function automatic logic [1:0] exp_flags(input int k, input int i);
    int p;
    p = i % (fw(k) + 3);
    return {(p == 0), (p == fw(k) + 2)};
  endfunction

  // Reference model and transfer recorder; sampled on the falling edge, so the
  // values seen describe what the next rising edge will do.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        got_w[k].delete(); got_f[k].delete(); got_c[k].delete(); acc[k].delete();
        occ[k] = 0; pos[k] = 0; stall_err[k] = 0;
        m_ovf[k] = 1'b0; m_fcnt[k] = 16'd0; held[k] = 1'b0;
      end
      run_prev = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic pop, last;
        pop  = 1'b0;
        last = 1'b0;
        if (held[k] && (o_en[k] !== 1'b1 || o_data[k] !== h_data[k] ||
                        o_fs[k] !== h_fs[k] || o_fe[k] !== h_fe[k]))
          stall_err[k]++;
        if (o_en[k] === 1'b1 && iOutReady) begin
          got_w[k].push_back(o_data[k]);
          got_f[k].push_back({o_fs[k], o_fe[k]});
          got_c[k].push_back(cyc);
          pop  = (pos[k] >= 2) && (pos[k] <= fw(k) + 1);
          last = (pos[k] == fw(k) + 2);
          pos[k] = last ? 0 : pos[k] + 1;
        end
        held[k]   = (o_en[k] === 1'b1) && !iOutReady;
        h_data[k] = o_data[k];
        h_fs[k]   = o_fs[k];
        h_fe[k]   = o_fe[k];
        if (last) m_fcnt[k] = m_fcnt[k] + 16'd1;
        if (iRunStart && !run_prev) begin
          m_ovf[k]  = 1'b0;
          m_fcnt[k] = 16'd0;
        end
        if (iRunStart && iData_en) begin
          if (occ[k] < DEPTH || pop) begin
            acc[k].push_back(iData);
            occ[k]++;
          end else begin
            m_ovf[k] = 1'b1;
          end
        end
        if (pop) occ[k]--;
      end
      run_prev = iRunStart;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic run);
    reset = 1'b1; iRunStart = run; iData_en = 1'b0; iOutReady = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic write_seq(input int n, input logic [15:0] base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      iData_en = 1'b1;
      iData    = rnd ? 16'($urandom) : base + 16'(i);
      tick();
    end
    iData_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; iRunStart = 1'b0; iData_en = 1'b0; iData = '0; iOutReady = 1'b0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_en[k], o_data[k], o_fs[k], o_fe[k], o_ovf[k], o_cnt[k]} !== 35'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got en=%b data=%h fs=%b fe=%b ovf=%b cnt=%h required all 0",
                 k, o_en[k], o_data[k], o_fs[k], o_fe[k], o_ovf[k], o_cnt[k]);
      end
    end
    reset = 1'b0;
    iRunStart = 1'b1; iOutReady = 1'b1;
    write_seq(3, 16'h0010, 1'b0);
    repeat (10) tick();
    checks++;
    if (got_w[0].size() != 0 || o_en[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_count_zero: got %0d transfers en=%b required 0 transfers en=0",
               got_w[0].size(), o_en[0]);
    end
  endtask

  task automatic test_basic();
    do_reset(1'b1);
    iOutReady = 1'b1;
    write_seq(4, 16'h0000, 1'b0);
    for (int c = 0; c < 40 && got_w[0].size() < 7; c++) tick();
    repeat (3) tick();
    checks++;
    if (got_w[0].size() != 7) begin
      errors++;
      $display("FAIL basic_len: got %0d words required 7", got_w[0].size());
    end
    for (int i = 0; i < 7 && i < got_w[0].size(); i++) begin
      checks++;
      if (got_w[0][i] !== BEXP[i] || got_f[0][i] !== {(i == 0), (i == 6)}) begin
        errors++;
        $display("FAIL basic_word[%0d]: got %h flags %b required %h flags %b",
                 i, got_w[0][i], got_f[0][i], BEXP[i], {(i == 0), (i == 6)});
      end
    end
    for (int i = 1; i < got_c[0].size(); i++) begin
      checks++;
      if (got_c[0][i] != got_c[0][i-1] + 1) begin
        errors++;
        $display("FAIL basic_consecutive[%0d]: got gap %0d required 1", i, got_c[0][i] - got_c[0][i-1]);
      end
    end
    checks++;
    if (o_cnt[0] !== 16'd1) begin
      errors++;
      $display("FAIL basic_framecnt: got %0d required 1", o_cnt[0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1);
    iOutReady = 1'b1;
    write_seq(4, 16'h0000, 1'b0);
    for (int c = 0; c < 80 && got_w[0].size() < 7; c++) begin
      iOutReady = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    iOutReady = 1'b1;
    repeat (4) tick();
    checks++;
    if (got_w[0].size() != 7) begin
      errors++;
      $display("FAIL bp_len: got %0d words required 7", got_w[0].size());
    end
    for (int i = 0; i < 7 && i < got_w[0].size(); i++) begin
      checks++;
      if (got_w[0][i] !== BEXP[i] || got_f[0][i] !== {(i == 0), (i == 6)}) begin
        errors++;
        $display("FAIL bp_word[%0d]: got %h flags %b required %h flags %b",
                 i, got_w[0][i], got_f[0][i], BEXP[i], {(i == 0), (i == 6)});
      end
    end
    checks++;
    if (stall_err[0] != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable stall cycles required 0", stall_err[0]);
    end
    checks++;
    if (got_c[0].size() == 7 && got_c[0][6] - got_c[0][0] < 7) begin
      errors++;
      $display("FAIL bp_stalled: got span %0d cycles required at least 7", got_c[0][6] - got_c[0][0]);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] e;
    int p, f;
    do_reset(1'b1);
    iOutReady = 1'b0;
    write_seq(32, 16'h0000, 1'b0);
    checks++;
    if (o_ovf[1] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_not_yet: got %b required 0", o_ovf[1]);
    end
    write_seq(1, 16'h0020, 1'b0);
    checks++;
    if (o_ovf[1] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b required 1", o_ovf[1]);
    end
    checks++;
    if (o_en[1] !== 1'b1 || o_data[1] !== HDR || o_fs[1] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_header_held: got en=%b data=%h fs=%b required 1 %h 1", o_en[1], o_data[1], o_fs[1], HDR);
    end
    iOutReady = 1'b1;
    for (int c = 0; c < 200 && got_w[1].size() < 38; c++) tick();
    repeat (30) tick();
    checks++;
    if (got_w[1].size() != 38) begin
      errors++;
      $display("FAIL ovf_len: got %0d words required 38", got_w[1].size());
    end
    for (int i = 0; i < 38 && i < got_w[1].size(); i++) begin
      f = i / 19;
      p = i % 19;
      e = (p == 0) ? HDR : (p == 1) ? 16'(f) : (p == 18) ? TRL : 16'(f * 16 + p - 2);
      checks++;
      if (got_w[1][i] !== e || got_f[1][i] !== {(p == 0), (p == 18)}) begin
        errors++;
        $display("FAIL ovf_word[%0d]: got %h flags %b required %h flags %b",
                 i, got_w[1][i], got_f[1][i], e, {(p == 0), (p == 18)});
      end
    end
    checks++;
    if (o_ovf[1] !== 1'b1 || o_cnt[1] !== 16'd2) begin
      errors++;
      $display("FAIL ovf_after: got ovf=%b cnt=%0d required ovf=1 cnt=2", o_ovf[1], o_cnt[1]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    iOutReady = 1'b0;
    write_seq(8, 16'h0100, 1'b1);
    tick();
    iOutReady = 1'b1;
    for (int c = 0; c < 60 && got_w[0].size() < 14; c++) tick();
    repeat (5) tick();
    checks++;
    if (got_w[0].size() != 14) begin
      errors++;
      $display("FAIL b2b_len: got %0d words required 14", got_w[0].size());
    end
    for (int i = 0; i < got_w[0].size(); i++) begin
      checks++;
      if (got_w[0][i] !== exp_word(0, i) || got_f[0][i] !== exp_flags(0, i)) begin
        errors++;
        $display("FAIL b2b_word[%0d]: got %h flags %b required %h flags %b",
                 i, got_w[0][i], got_f[0][i], exp_word(0, i), exp_flags(0, i));
      end
    end
    checks++;
    if (got_c[0].size() == 14 && got_c[0][7] != got_c[0][6] + 2) begin
      errors++;
      $display("FAIL b2b_idle_gap: got %0d cycles required 2", got_c[0][7] - got_c[0][6]);
    end
    checks++;
    if (o_cnt[0] !== 16'd2) begin
      errors++;
      $display("FAIL b2b_framecnt: got %0d required 2", o_cnt[0]);
    end
  endtask

  task automatic test_run_gating();
    do_reset(1'b0);
    iOutReady = 1'b1;
    write_seq(10, 16'h0040, 1'b0);
    repeat (30) tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_w[k].size() != 0 || o_ovf[k] !== 1'b0 || o_en[k] !== 1'b0) begin
        errors++;
        $display("FAIL gate_idle[%0d]: got %0d words ovf=%b en=%b required 0 0 0",
                 k, got_w[k].size(), o_ovf[k], o_en[k]);
      end
    end
    iRunStart = 1'b1;
    iOutReady = 1'b0;
    write_seq(33, 16'h0200, 1'b1);
    iOutReady = 1'b1;
    for (int c = 0; c < 300 && got_w[0].size() < 56; c++) tick();
    repeat (20) tick();
    checks++;
    if (o_ovf[0] !== 1'b1 || o_cnt[0] !== 16'd8 || o_ovf[1] !== 1'b1 || o_cnt[1] !== 16'd2) begin
      errors++;
      $display("FAIL gate_run: got ovf=%b/%b cnt=%0d/%0d required 1/1 8/2",
               o_ovf[0], o_ovf[1], o_cnt[0], o_cnt[1]);
    end
    for (int i = 0; i < got_w[0].size(); i++) begin
      checks++;
      if (got_w[0][i] !== exp_word(0, i)) begin
        errors++;
        $display("FAIL gate_word[%0d]: got %h required %h", i, got_w[0][i], exp_word(0, i));
      end
    end
    iRunStart = 1'b0;
    tick();
    iRunStart = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_ovf[k] !== 1'b0 || o_cnt[k] !== 16'd0) begin
        errors++;
        $display("FAIL gate_restart[%0d]: got ovf=%b cnt=%0d required 0 0", k, o_ovf[k], o_cnt[k]);
      end
    end
  endtask

  task automatic test_random();
    int nf;
    do_reset(1'b1);
    for (int c = 0; c < 800; c++) begin
      iData_en  = ($urandom_range(0, 99) < 45);
      iData     = 16'($urandom);
      iOutReady = ($urandom_range(0, 3) != 0);
      tick();
    end
    iData_en  = 1'b0;
    iOutReady = 1'b1;
    repeat (150) tick();
    for (int k = 0; k < 2; k++) begin
      nf = acc[k].size() / fw(k);
      checks++;
      if (got_w[k].size() != nf * (fw(k) + 3)) begin
        errors++;
        $display("FAIL rand_len[%0d]: got %0d words required %0d", k, got_w[k].size(), nf * (fw(k) + 3));
      end
      for (int i = 0; i < got_w[k].size(); i++) begin
        checks++;
        if (got_w[k][i] !== exp_word(k, i) || got_f[k][i] !== exp_flags(k, i)) begin
          errors++;
          $display("FAIL rand_word[%0d][%0d]: got %h flags %b required %h flags %b",
                   k, i, got_w[k][i], got_f[k][i], exp_word(k, i), exp_flags(k, i));
        end
      end
      checks++;
      if (stall_err[k] != 0 || o_ovf[k] !== m_ovf[k] || o_cnt[k] !== m_fcnt[k]) begin
        errors++;
        $display("FAIL rand_status[%0d]: got stall_err=%0d ovf=%b cnt=%0d required 0 %b %0d",
                 k, stall_err[k], o_ovf[k], o_cnt[k], m_ovf[k], m_fcnt[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset(1'b1);
    iOutReady = 1'b1;
    write_seq(12, 16'h0300, 1'b1);
    for (int c = 0; c < 60 && got_w[0].size() < 17; c++) tick();
    checks++;
    if (o_en[0] !== 1'b1 || o_cnt[0] !== 16'd2) begin
      errors++;
      $display("FAIL midrst_pre: got en=%b cnt=%0d required 1 2", o_en[0], o_cnt[0]);
    end
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_en[k], o_data[k], o_fs[k], o_fe[k], o_ovf[k], o_cnt[k]} !== 35'd0) begin
        errors++;
        $display("FAIL midrst_async[%0d]: got en=%b data=%h fs=%b fe=%b ovf=%b cnt=%h required all 0",
                 k, o_en[k], o_data[k], o_fs[k], o_fe[k], o_ovf[k], o_cnt[k]);
      end
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    write_seq(4, 16'h0A00, 1'b0);
    for (int c = 0; c < 40 && got_w[0].size() < 7; c++) tick();
    repeat (5) tick();
    checks++;
    if (got_w[0].size() != 7) begin
      errors++;
      $display("FAIL midrst_len: got %0d words required 7", got_w[0].size());
    end
    for (int i = 0; i < got_w[0].size(); i++) begin
      checks++;
      if (got_w[0][i] !== exp_word(0, i) || got_w[0][i][15:8] == 8'h03 && i >= 2 && i <= 5) begin
        errors++;
        $display("FAIL midrst_word[%0d]: got %h required %h", i, got_w[0][i], exp_word(0, i));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_run_gating();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/daq_frame_packer.md
Name: daq_frame_packer

Overview:
- Sits directly downstream of the ADC/test data source.
- Accepts its single-cycle 16-bit word strobes, buffers them in an internal FIFO, and emits fixed-length frames toward the SRAM/Ethernet path.
- Frame format: header word, frame number, FRAME_WORDS payload words, trailer word.
- Output uses a valid/ready handshake so that downstream stalls never corrupt a frame.

Parameters:
- FRAME_WORDS, 16: payload words per frame, range 1..2^FIFO_AW.
- FIFO_AW, 5: FIFO address width; depth = 2^FIFO_AW = 32.
- HEADER, 16'hEB90: first word of every frame.
- TRAILER, 16'h55AA: last word of every frame.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- iRunStart  in  1  run enable; input words are accepted only while high.
- iData_en  in  1  one-cycle strobe; iData is valid.
- iData  in  16  input data word.
- iOutReady  in  1  downstream can accept oData this cycle.
- oData_en  out  1  oData is valid.
- oData  out  16  frame word.
- oFrameStart  out  1  high with the header word.
- oFrameEnd  out  1  high with the trailer word.
- oOverflow  out  1  sticky: an input word was dropped.
- oFrameCnt  out  16  number of frames completed.

Behaviour:
- Reset (async, active-high):
  - oData_en=0, oData=0, oFrameStart=0, oFrameEnd=0, oOverflow=0, oFrameCnt=0.
  - FIFO empty (pointers and count = 0); state = IDLE.
  - Takes effect immediately, including mid-frame; the partial frame is abandoned.
- Input side:
  - Write when iRunStart && iData_en.
  - The write is accepted if the FIFO count < depth, or if a payload pop occurs in the same cycle.
  - Otherwise the word is dropped and oOverflow is set (same-cycle register update).
  - While iRunStart=0, iData_en is ignored and does not set overflow.
- Run start: the rising edge of iRunStart (registered previous value 0, current 1) clears oOverflow and oFrameCnt on that edge. The FIFO is not flushed and any frame in progress is not affected.
- Transfer rule:
  - A word transfers on a clock edge with oData_en && iOutReady.
  - While oData_en=1 and iOutReady=0, oData, oFrameStart and oFrameEnd hold stable.
  - After a transfer, the next word of the frame is presented on the following cycle (registered).
  - Sustained throughput is one word/cycle with iOutReady held high.
- State machine (FIFO count is the registered count):
  - IDLE: oData_en=0. Go to HEADER when count >= FRAME_WORDS; the header appears on oData the next cycle. A frame is never started with insufficient data, so payload never underflows.
  - HEADER: oData=HEADER, oFrameStart=1. On transfer go to FNUM.
  - FNUM: oData=oFrameCnt. On transfer go to PAYLOAD.
  - PAYLOAD: oData = FIFO head. Each transfer pops one word. After FRAME_WORDS transfers go to TRAILER.
  - TRAILER: oData=TRAILER, oFrameEnd=1. On transfer: oFrameCnt+1 (wraps 16'hFFFF -> 0), then go to IDLE.
- Frame length is always FRAME_WORDS+3 words.
- Back-to-back frames: with ≥ FRAME_WORDS still buffered at TRAILER transfer, one IDLE cycle (oData_en=0) precedes the next header.
- If iRunStart falls mid-frame, the frame completes normally. Leftover words (< FRAME_WORDS) stay buffered until the next run fills them.
- FIFO count width FIFO_AW+1; pointers wrap modulo depth.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle -> all outputs 0 immediately, with no clk edge required; count=0 after release.
- Basic frame (FRAME_WORDS=4, iOutReady=1, iRunStart=1): strobe iData 0x0000..0x0003 -> oData sequence EB90,0000,0000,0001,0002,0003,55AA on consecutive cycles; oFrameStart only on EB90, oFrameEnd only on 55AA; oFrameCnt=1 after the trailer.
- Backpressure: same stimulus with iOutReady toggling 1,0,0,1,... -> each word held stable while ready=0; the sequence matches the basic frame exactly with no duplicates or gaps.
- Overflow (FRAME_WORDS=16, iOutReady=0): write 33 words 0..32 -> word 32 dropped and oOverflow=1. Release ready -> two frames carrying payload 0..15 and 16..31; FNUM words 0 then 1; oOverflow remains 1.
- Run gating: iRunStart=0 while strobing 10 words -> FIFO count stays 0, no frames, no overflow. Then a 0->1 edge of iRunStart -> oOverflow and oFrameCnt cleared to 0.
- Reset mid-frame: assert reset during PAYLOAD of frame 3 -> outputs cleared. After release, the next full frame carries FNUM=0000 and payload from fresh input only.
